// File: rtl/fact_pkg.sv
// Shared types and helpers for the sequential factorial unit.
package fact_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } fact_state_t;

   // The accumulator restarts from the multiplicative identity on every accepted request.
   localparam int FACT_ONE = 1;

   // Largest n whose factorial still fits in an out_w-bit unsigned result.
   function automatic int fact_max_n(input int out_w);
      logic [127:0] f;
      f = 128'd1;
      for (int k = 1; k < 35; k++) begin
         f = f * 128'(k);
         if ((f >> out_w) != 128'd0) return k - 1;
      end
      return 34;
   endfunction

endpackage

// File: rtl/fact_mul.sv
// Combinational OUT_W x N_W multiplier step for fact_seq; hi_nz flags a product
// that no longer fits in OUT_W bits. Kept separate so it can be swapped for a pipelined unit.
module fact_mul #(
   parameter int OUT_W = 32,
   parameter int N_W   = 4
) (
   input  logic [OUT_W-1:0] a,
   input  logic [N_W-1:0]   b,
   output logic [OUT_W-1:0] prod_lo,
   output logic             hi_nz
);

   logic [OUT_W+N_W-1:0] prod;

   assign prod    = {{N_W{1'b0}}, a} * {{OUT_W{1'b0}}, b};
   assign prod_lo = prod[OUT_W-1:0];
   assign hi_nz   = |prod[OUT_W+N_W-1:OUT_W];

endmodule

// File: rtl/fact_seq.sv
// Iterative n! unit, one multiply per clock, behind a start/done handshake.
// Define FACT_SEQ_SAT_EN to saturate result to all-ones when the true factorial overflows.
module fact_seq
   import fact_pkg::*;
#(
   parameter int N_W   = 4,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_W-1:0]   n,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] result,
   output logic             ovf
);

   fact_state_t      state_q;
   logic [OUT_W-1:0] acc_q;
   logic [N_W-1:0]   cnt_q;
   logic [OUT_W-1:0] result_q;
   logic             ovf_q;

   logic [OUT_W-1:0] acc_d;
   logic             hi_nz_d;

   fact_mul #(
      .OUT_W(OUT_W),
      .N_W  (N_W)
   ) u_mul (
      .a      (acc_q),
      .b      (cnt_q),
      .prod_lo(acc_d),
      .hi_nz  (hi_nz_d)
   );

   // NOTE: every register here uses <= so all updates see the pre-edge values of their peers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  acc_q   <= OUT_W'(FACT_ONE);
                  cnt_q   <= n;
                  ovf_q   <= 1'b0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               // n=0 and n=1 fall straight through with acc still at one.
               if (cnt_q <= N_W'(1)) begin
                  state_q <= DONE;
`ifdef FACT_SEQ_SAT_EN
                  result_q <= ovf_q ? {OUT_W{1'b1}} : acc_q;
`else
                  result_q <= acc_q;
`endif
               end else begin
                  acc_q <= acc_d;
                  ovf_q <= ovf_q | hi_nz_d;
                  cnt_q <= cnt_q - N_W'(1);
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign ovf    = ovf_q;

endmodule

// File: doc/fact_seq.md
Name: fact_seq

Overview:
Sequential, parametrised factorial unit that computes n! iteratively, one multiply per clock, behind a start/done handshake. It is the clocked successor to the combinational factorial block. It generalises input and output widths and adds overflow detection, so wide n can be served without a huge combinational multiplier chain. It sits as a compute leaf under any controller that can issue start and wait for done.

Parameters:
N_W, 4, width of operand n (n ranges 0..2^N_W-1)
OUT_W, 32, width of result; products are kept modulo 2^OUT_W; must be >= N_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
n  input  N_W  operand, captured on the accepting edge
busy  output  1  high in CALC and DONE
done  output  1  one-cycle pulse: result/ovf valid
result  output  OUT_W  n! mod 2^OUT_W (see SAT_EN); held until next accepted start
ovf  output  1  true n! exceeds 2^OUT_W-1; held with result

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst sampled high at a clk edge forces state=IDLE, busy=0, done=0, result=0, ovf=0, internal acc=0, cnt=0. rst has priority over everything. Reset mid-operation aborts the calculation with no done pulse.
- States: IDLE, CALC, DONE. All outputs are registered or decoded from the state register; there are no combinational paths from start or n to outputs.
- IDLE, start=1: acc<=1, cnt<=n, ovf<=0, state<=CALC. IDLE, start=0: hold.
- CALC, cnt<=1: state<=DONE; result<=acc (SAT_EN: all-ones if ovf).
- CALC, cnt>1: acc<=low OUT_W bits of acc*cnt; ovf<=ovf | (upper N_W bits of full OUT_W+N_W product != 0); cnt<=cnt-1.
- DONE: done=1 for exactly this cycle; state<=IDLE unconditionally.
- Latency: done is high in the cycle following the clock edge that is max(n,1) edges after the accepting edge. n=0 and n=1 both take 1 cycle and give result=1.
- start during CALC or DONE is ignored; n is not re-sampled. The earliest back-to-back start is in the cycle after done (IDLE).
- Between runs, result and ovf hold their last values. Their value during CALC is the previous run's output (result is updated only on the CALC->DONE edge). ovf is internally cleared at acceptance, so the previous ovf is not held during CALC.
- Modular accumulation is exact: per-step truncation equals n! mod 2^OUT_W.

Optional Feature:
FACT_SEQ_SAT_EN
- Defined: when ovf=1, result is loaded with {OUT_W{1'b1}} on the CALC->DONE edge. ovf behaves identically.
- Undefined: result = n! mod 2^OUT_W regardless of ovf.

Decomposition:
- Package fact_pkg:
  - state enum fact_state_t {IDLE, CALC, DONE}.
  - Constant FACT_ONE (acc reset-to-1 helper).
  - Function for the expected max non-overflow n per OUT_W (used by the bench).
- Sub-module fact_mul: combinational OUT_W x N_W multiplier.
  - Outputs prod_lo[OUT_W-1:0] and a hi_nz overflow bit.
  - One instance in fact_seq. Keeps the datapath replaceable (e.g. a pipelined multiplier later).

Test Plan:
- Reset, then n=0 start pulse: done after 1 cycle, result=1, ovf=0. Repeat with n=1: identical.
- n=5: done exactly 5 cycles after the accepting edge, result=120, ovf=0; busy high throughout CALC and DONE.
- n=12: result=479001600 (0x1C8CFC00), ovf=0.
- n=13: result=1932053504 (0x7328CC00), ovf=1. Define FACT_SEQ_SAT_EN and rerun: result=0xFFFFFFFF, ovf=1. n=15 without SAT_EN: result=0x77775800, ovf=1.
- Start n=7, then pulse start with n=3 in CALC: ignored, result=5040. Immediate restart in the cycle after done with n=4: result=24.
- Start n=10, assert rst for one cycle mid-CALC: no done pulse, all outputs 0 next cycle. Then start n=6: result=720.
